// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths and the queued write-back payload type.
package regfile_writeback_queue_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Enqueue handshake between the MEM/WB register and the write-back queue.
interface regfile_writeback_queue_if;
  import regfile_writeback_queue_pkg::*;

  logic                  enq_valid;
  logic                  enq_ready;
  logic [REG_ADDR_W-1:0] enq_rd;
  logic [XLEN-1:0]       enq_data;

  modport master (output enq_valid, output enq_rd, output enq_data, input enq_ready);
  modport slave  (input enq_valid, input enq_rd, input enq_data, output enq_ready);

endinterface

// File: rtl/regfile_writeback_queue_fwd_match.sv
// Newest-first forwarding match over age-ordered queue entries plus the output register.
module regfile_writeback_queue_fwd_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]  i_entries,
  input  logic      [DEPTH-1:0]  i_valid,
  input  wb_entry_t              i_out_entry,
  input  logic                   i_out_valid,
  input  logic [REG_ADDR_W-1:0]  i_lookup,
  output logic                   o_hit_c,
  output logic [XLEN-1:0]        o_data_c
);

  // Index 0 is oldest; later matches override earlier ones, output register is weakest.
  always_comb begin
    o_hit_c  = 1'b0;
    o_data_c = '0;
    if (i_lookup != '0) begin
      if (i_out_valid && (i_out_entry.rd == i_lookup)) begin
        o_hit_c  = 1'b1;
        o_data_c = i_out_entry.data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_valid[i] && (i_entries[i].rd == i_lookup)) begin
          o_hit_c  = 1'b1;
          o_data_c = i_entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue draining one result per cycle into the register file,
// with forwarding of still-pending values to decode.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_writeback_queue_if.slave    enq,
  input  logic                        wb_stall,
  output logic                        reg_write,
  output logic [REG_ADDR_W-1:0]       write_reg,
  output logic [XLEN-1:0]             write_data,
  input  logic [REG_ADDR_W-1:0]       lookup_reg1,
  input  logic [REG_ADDR_W-1:0]       lookup_reg2,
  output logic                        fwd_hit1,
  output logic                        fwd_hit2,
  output logic [XLEN-1:0]             fwd_data1,
  output logic [XLEN-1:0]             fwd_data2,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t             r_mem [DEPTH];
  logic [PW:0]           r_head;
  logic [PW:0]           r_tail;
  logic                  r_out_valid;
  wb_entry_t             r_out;

  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  wb_entry_t             w_enq_entry;
  wb_entry_t [DEPTH-1:0] w_age_entries;
  logic [DEPTH-1:0]      w_age_valid;

  // Writes to x0 complete the handshake but are dropped.
  assign w_count     = r_tail - r_head;
  assign w_full      = (w_count == CW'(DEPTH));
  assign w_push      = enq.enq_valid && !w_full && (enq.enq_rd != '0);
  assign w_pop       = (w_count != '0) && !wb_stall;
  assign w_enq_entry = '{rd: enq.enq_rd, data: enq.enq_data};

  assign enq.enq_ready = !w_full;
  assign occupancy     = w_count;
  assign reg_write     = r_out_valid;
  assign write_reg     = r_out.rd;
  assign write_data    = r_out.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + CW'(1);
      end
      if (w_pop) begin
        r_head      <= r_head + CW'(1);
        r_out       <= r_mem[r_head[PW-1:0]];
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail[PW-1:0]] <= w_enq_entry;
    end
  end

  // Present entries oldest-first so the matcher can apply age priority by index.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_age_entries[i] = r_mem[PW'(r_head[PW-1:0] + PW'(i))];
      w_age_valid[i]   = (CW'(i) < w_count);
    end
  end

  regfile_writeback_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .i_entries   (w_age_entries),
    .i_valid     (w_age_valid),
    .i_out_entry (r_out),
    .i_out_valid (r_out_valid),
    .i_lookup    (lookup_reg1),
    .o_hit_c     (fwd_hit1),
    .o_data_c    (fwd_data1)
  );

  regfile_writeback_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .i_entries   (w_age_entries),
    .i_valid     (w_age_valid),
    .i_out_entry (r_out),
    .i_out_valid (r_out_valid),
    .i_lookup    (lookup_reg2),
    .o_hit_c     (fwd_hit2),
    .o_data_c    (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed plus randomized bench for regfile_writeback_queue against a queue-based model.
module tb_regfile_writeback_queue;
  import regfile_writeback_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wb_stall;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]       write_data;
  logic [REG_ADDR_W-1:0] lookup_reg1;
  logic [REG_ADDR_W-1:0] lookup_reg2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [XLEN-1:0]       fwd_data1;
  logic [XLEN-1:0]       fwd_data2;
  logic [CW-1:0]         occupancy;

  regfile_writeback_queue_if enq_if ();

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq         (enq_if),
    .wb_stall    (wb_stall),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .lookup_reg1 (lookup_reg1),
    .lookup_reg2 (lookup_reg2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Reference state: pending writes in acceptance order plus the last drained write.
  wb_entry_t       m_q[$];
  logic            m_out_v;
  wb_entry_t       m_out;
  logic [XLEN-1:0] rf [32];
  int              n_vec   = 0;
  int              n_err   = 0;
  int              n_writes = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void exp_fwd(input logic [REG_ADDR_W-1:0] lk,
                                  output logic hit, output logic [XLEN-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (lk == '0) return;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].rd == lk) begin
        hit  = 1'b1;
        data = m_q[i].data;
        return;
      end
    end
    if (m_out_v && m_out.rd == lk) begin
      hit  = 1'b1;
      data = m_out.data;
    end
  endfunction

  task automatic model_step();
    bit pop;
    bit acc;
    if (rst) begin
      m_q.delete();
      m_out_v = 1'b0;
      m_out   = '0;
    end else begin
      pop = (m_q.size() > 0) && !wb_stall;
      acc = enq_if.enq_valid && (m_q.size() < DEPTH);
      if (pop) begin
        m_out   = m_q.pop_front();
        m_out_v = 1'b1;
      end else begin
        m_out_v = 1'b0;
      end
      if (acc && enq_if.enq_rd != '0)
        m_q.push_back('{rd: enq_if.enq_rd, data: enq_if.enq_data});
    end
  endtask

  task automatic check_outputs();
    logic            h1, h2;
    logic [XLEN-1:0] d1, d2;
    exp_fwd(lookup_reg1, h1, d1);
    exp_fwd(lookup_reg2, h2, d2);
    check_val("occupancy",  64'(occupancy),        64'(m_q.size()));
    check_val("enq_ready",  64'(enq_if.enq_ready), 64'(m_q.size() < DEPTH));
    check_val("reg_write",  64'(reg_write),        64'(m_out_v));
    check_val("write_reg",  64'(write_reg),        64'(m_out.rd));
    check_val("write_data", 64'(write_data),       64'(m_out.data));
    check_val("fwd_hit1",   64'(fwd_hit1),         64'(h1));
    check_val("fwd_data1",  64'(fwd_data1),        64'(d1));
    check_val("fwd_hit2",   64'(fwd_hit2),         64'(h2));
    check_val("fwd_data2",  64'(fwd_data2),        64'(d2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (reg_write === 1'b1) begin
      rf[write_reg] = write_data;
      n_writes++;
    end
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [REG_ADDR_W-1:0] rd,
                       input logic [XLEN-1:0] d, input logic st);
    enq_if.enq_valid = v;
    enq_if.enq_rd    = rd;
    enq_if.enq_data  = d;
    wb_stall         = st;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    m_out_v     = 1'b0;
    m_out       = '0;
    rst         = 1'b1;
    lookup_reg1 = 5'd5;
    lookup_reg2 = 5'd10;
    drive(1'b0, '0, '0, 1'b0);

    // Reset state
    tick();
    tick();
    check_val("rst_ready", 64'(enq_if.enq_ready), 64'd1);
    rst = 1'b0;

    // Back-to-back enqueue, readback through captured writes
    drive(1'b1, 5'd5, 32'd123, 1'b0);
    tick();
    drive(1'b1, 5'd10, 32'd999, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (4) tick();
    check_val("rf_x5",  64'(rf[5]),  64'd123);
    check_val("rf_x10", 64'(rf[10]), 64'd999);

    // Fill under stall, overflow attempt, then drain
    lookup_reg1 = 5'd3;
    lookup_reg2 = 5'd6;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(100 + i), 1'b1);
      tick();
    end
    check_val("full_occ",   64'(occupancy),        64'd4);
    check_val("full_ready", 64'(enq_if.enq_ready), 64'd0);
    drive(1'b1, 5'd6, 32'd666, 1'b1);
    repeat (2) tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (6) tick();
    for (int i = 1; i <= 4; i++) check_val("drain_rf", 64'(rf[i]), 64'(100 + i));
    check_val("held_x6", 64'(rf[6]), 64'd0);
    check_val("drain_occ", 64'(occupancy), 64'd0);

    // Newest duplicate wins forwarding; x0 lookup never hits
    lookup_reg1 = 5'd7;
    lookup_reg2 = 5'd0;
    drive(1'b1, 5'd7, 32'd1, 1'b1);
    tick();
    drive(1'b1, 5'd7, 32'd2, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check_val("dup_hit1",  64'(fwd_hit1),  64'd1);
    check_val("dup_data1", 64'(fwd_data1), 64'd2);
    check_val("x0_hit2",   64'(fwd_hit2),  64'd0);
    drive(1'b0, '0, '0, 1'b0);
    repeat (4) tick();

    // Enqueue to x0 is swallowed
    w0 = n_writes;
    drive(1'b1, 5'd0, 32'd55, 1'b0);
    tick();
    check_val("x0_occ", 64'(occupancy), 64'd0);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    check_val("x0_nowrite", 64'(n_writes - w0), 64'd0);

    // Reset with entries pending drops them all
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 32'(200 + i), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w0 = n_writes;
    repeat (5) tick();
    check_val("rst_nowrite", 64'(n_writes - w0), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3));
      lookup_reg1 = 5'($urandom_range(0, 7));
      lookup_reg2 = 5'($urandom_range(0, 7));
      rst = 1'($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
